sensor_sample_generator: RTL and testbench
==========================================

SENSOR_SAMPLE_GENERATOR -- requirements
Module: sensor_sample_generator

Interface
REQ-001 The block SHALL have a parameter TICKS_PER_SEC, default 50_000_000, giving the number of clk cycles in one sample window (legal range 2 to 2^26).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port run, input, 1 bit: 1 = measuring, 0 = stopped.
REQ-005 Port step_pulse, input, 1 bit: pedometer step level, already synchronous to clk; each rising edge is one step.
REQ-006 Port beat_pulse, input, 1 bit: heart-beat level, already synchronous to clk; each rising edge is one beat.
REQ-007 Port stride_in, input, 8 bits: current stride length.
REQ-008 Port hr_out, output, 8 bits: heart rate in bpm for the step calculator's hr_input.
REQ-009 Port steps_per_second, output, 2 bits: steps counted in the last window.
REQ-010 Port stride_length, output, 8 bits: stride_in as sampled at window close.
REQ-011 Port valid_out, output, 1 bit: one-cycle strobe marking a new sample; drives valid_input of the step calculator.
REQ-012 Port warming_up, output, 1 bit: 1 while in WARMUP.

Function
REQ-013 The block SHALL detect rising edges using one registered previous value per input; an edge is current=1 and previous=0.
REQ-014 Edge-detect registers SHALL track their input in every state, including IDLE.
REQ-015 The state machine SHALL have three states: IDLE, WARMUP and RUN.
- IDLE -> WARMUP when run=1.
- WARMUP -> RUN at the 4th window close.
- RUN or WARMUP -> IDLE when run=0.
REQ-016 In IDLE the block SHALL:
- hold the tick counter, step count, beat count and filled count at 0;
- clear all four beat-history entries;
- ignore edges;
- keep valid_out at 0.
REQ-017 The tick counter (26 bits) SHALL increment each cycle in WARMUP and RUN; a window closes in the cycle the counter equals TICKS_PER_SEC-1, and the counter then wraps to 0.
REQ-018 Per-window step count SHALL saturate at 3, and per-window beat count (4 bits) SHALL saturate at 15.
REQ-019 An edge in the window-close cycle SHALL count toward the closing window; the new window starts from 0.
REQ-020 Simultaneous step and beat edges SHALL both be counted.
REQ-021 At each window close, the closing beat count SHALL be written into a 4-entry circular history buffer at the write pointer, which then advances mod 4.
REQ-022 At each window close, the 3-bit filled count SHALL increment, saturating at 4.
REQ-023 At a window close in RUN, or at the 4th close in WARMUP, the next cycle SHALL assert valid_out for exactly one cycle, with these registered values:
- steps_per_second = closing step count;
- stride_length = stride_in sampled in the close cycle;
- hr_out = min(255, 15 * (sum of all 4 history entries including the new entry)).
REQ-024 The sum SHALL be computed 10 bits wide and the product 10 bits wide (maximum 900) before saturating to 8 bits.
REQ-025 WARMUP window closes before the 4th SHALL NOT assert valid_out.
REQ-026 If run falls mid-window, the partial window SHALL be discarded, with no valid_out and no history write; a close coinciding with run=0 is also discarded.
REQ-027 hr_out, steps_per_second and stride_length SHALL hold their last values between strobes and in IDLE.
REQ-028 warming_up SHALL be 1 exactly when the state is WARMUP.

Reset
REQ-029 When rst=1 at a clk edge, the block SHALL:
- enter IDLE;
- clear all counters, the history, the write pointer and the filled count;
- drive hr_out=0, steps_per_second=0, stride_length=0, valid_out=0 and warming_up=0;
- set both edge-detect registers to 1, so an input already high at reset release is not counted.
REQ-030 rst SHALL override run and any window close in the same cycle, including a pending valid_out.

Verification (TICKS_PER_SEC=10)
REQ-031 Scenario 1: rst, then run=1, 2 beats and 1 step per window for 4 windows -> no valid_out for windows 1-3; one-cycle valid_out after window 4 with hr_out=120, steps_per_second=1; warming_up falls at the same time.
REQ-032 Scenario 2: in RUN, 5 step edges in one window -> steps_per_second=3; 15 beats per window for 4 windows -> hr_out=255 (900 saturated).
REQ-033 Scenario 3: beat edge in the close cycle (counter=9) -> counted in the closing window, and the next window's beat count starts at 0.
REQ-034 Scenario 4: run dropped at counter=5 in RUN, then raised again -> no valid_out; warming_up=1; next valid_out only after 4 fresh windows, and the history is cleared (hr reflects only new beats).
REQ-035 Scenario 5: rst asserted in the close cycle of window 4 -> no valid_out; all outputs 0 the next cycle.
REQ-036 Scenario 6: step_pulse held high across rst release -> not counted; stride_in changed from 60 to 75 at counter=3 of a RUN window -> stride_length=75 at the strobe.

Source files
------------

// File: rtl/sensor_sample_generator.sv
// Sensor sample generator: turns pedometer step and heart-beat levels into
// per-window samples (steps per window, stride, heart rate) for the step
// calculator. The first four windows after start are a warm-up that fills the
// beat history. valid_out is withheld until all four history entries are real.
module sensor_sample_generator #(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       step_pulse,
   input  logic       beat_pulse,
   input  logic [7:0] stride_in,
   output logic [7:0] hr_out,
   output logic [1:0] steps_per_second,
   output logic [7:0] stride_length,
   output logic       valid_out,
   output logic       warming_up
);

   localparam logic [1:0]  S_IDLE    = 2'd0;
   localparam logic [1:0]  S_WARMUP  = 2'd1;
   localparam logic [1:0]  S_RUN     = 2'd2;
   localparam logic [25:0] TICK_LAST = 26'(TICKS_PER_SEC - 1);

   logic [1:0]  state;
   logic [25:0] tick_cnt;
   logic [1:0]  step_cnt;
   logic [3:0]  beat_cnt;
   logic [3:0]  hist [4];
   logic [1:0]  wr_ptr;
   logic [2:0]  filled;
   logic        step_prev;
   logic        beat_prev;

   logic        step_edge;
   logic        beat_edge;
   logic        active;
   logic        win_close;
   logic        emit;
   logic [1:0]  step_next;
   logic [3:0]  beat_next;
   logic [9:0]  hist_sum;
   logic [9:0]  hr_prod;

   // Heart rate is 15 x (beats over four windows); clamp to the 8-bit output.
   function automatic logic [7:0] sat_u8(input logic [9:0] v);
      return (v > 10'd255) ? 8'd255 : v[7:0];
   endfunction

   // Edge detection, saturating window counts, and the history sum that
   // already includes the entry being written this cycle.
   always_comb begin
      step_edge = step_pulse & ~step_prev;
      beat_edge = beat_pulse & ~beat_prev;
      active    = (state != S_IDLE) && run;
      win_close = active && (tick_cnt == TICK_LAST);
      step_next = (step_edge && (step_cnt != 2'd3))  ? step_cnt + 2'd1 : step_cnt;
      beat_next = (beat_edge && (beat_cnt != 4'd15)) ? beat_cnt + 4'd1 : beat_cnt;
      hist_sum  = 10'd0;
      for (int i = 0; i < 4; i++) begin
         hist_sum = hist_sum + ((2'(i) == wr_ptr) ? {6'd0, beat_next} : {6'd0, hist[i]});
      end
      hr_prod   = hist_sum * 10'd15;
      emit      = win_close &&
                  ((state == S_RUN) || ((state == S_WARMUP) && (filled == 3'd3)));
   end

   // Previous-value registers track their inputs in every state; a reset value
   // of 1 keeps an input that is already high at release from counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_prev <= 1'b1;
         beat_prev <= 1'b1;
      end else begin
         step_prev <= step_pulse;
         beat_prev <= beat_pulse;
      end
   end

   // State machine, window timing, per-window counts and beat history.
   // Any cycle that is not actively measuring (IDLE, or run just dropped)
   // discards the partial window and clears the history.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         tick_cnt <= '0;
         step_cnt <= '0;
         beat_cnt <= '0;
         wr_ptr   <= '0;
         filled   <= '0;
         for (int i = 0; i < 4; i++) hist[i] <= '0;
      end else if (!active) begin
         state    <= ((state == S_IDLE) && run) ? S_WARMUP : S_IDLE;
         tick_cnt <= '0;
         step_cnt <= '0;
         beat_cnt <= '0;
         filled   <= '0;
         for (int i = 0; i < 4; i++) hist[i] <= '0;
      end else if (win_close) begin
         tick_cnt     <= '0;
         step_cnt     <= '0;
         beat_cnt     <= '0;
         hist[wr_ptr] <= beat_next;
         wr_ptr       <= wr_ptr + 2'd1;
         filled       <= (filled == 3'd4) ? 3'd4 : filled + 3'd1;
         if ((state == S_WARMUP) && (filled == 3'd3)) state <= S_RUN;
      end else begin
         tick_cnt <= tick_cnt + 26'd1;
         step_cnt <= step_next;
         beat_cnt <= beat_next;
      end
   end

   // Sample outputs load on a strobe and hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out        <= 1'b0;
         hr_out           <= '0;
         steps_per_second <= '0;
         stride_length    <= '0;
      end else begin
         valid_out <= emit;
         if (emit) begin
            hr_out           <= sat_u8(hr_prod);
            steps_per_second <= step_next;
            stride_length    <= stride_in;
         end
      end
   end

   assign warming_up = (state == S_WARMUP);

endmodule

// File: tb/tb_sensor_sample_generator.sv
// Directed bench for sensor_sample_generator with TICKS_PER_SEC=10.
module tb_sensor_sample_generator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic       step_pulse = 1'b0;
   logic       beat_pulse = 1'b0;
   logic [7:0] stride_in = 8'd60;
   logic [7:0] hr_out;
   logic [1:0] steps_per_second;
   logic [7:0] stride_length;
   logic       valid_out;
   logic       warming_up;

   int total = 0;
   int bad   = 0;
   int vhits = 0;

   sensor_sample_generator #(.TICKS_PER_SEC(10)) dut (
      .clk              (clk),
      .rst              (rst),
      .run              (run),
      .step_pulse       (step_pulse),
      .beat_pulse       (beat_pulse),
      .stride_in        (stride_in),
      .hr_out           (hr_out),
      .steps_per_second (steps_per_second),
      .stride_length    (stride_length),
      .valid_out        (valid_out),
      .warming_up       (warming_up)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Run n cycles; bit c of sm/bm is the step/beat level for cycle c. stride_in
   // takes value sv before cycle sc. vhits counts valid_out highs seen on all
   // but the last sample; the last sample is left for the caller to check.
   task automatic drive(input int n, input logic [9:0] sm, input logic [9:0] bm,
                        input int sc, input logic [7:0] sv);
      vhits = 0;
      for (int c = 0; c < n; c++) begin
         step_pulse = sm[c];
         beat_pulse = bm[c];
         if (c == sc) stride_in = sv;
         @(posedge clk);
         #1;
         if ((c < n - 1) && valid_out) vhits++;
      end
   endtask

   task automatic chk_sample(input string tag, input int hr, input int sps, input int stride);
      chk({tag, "_mid_valid"}, vhits, 0);
      chk({tag, "_valid"}, 32'(valid_out), 1);
      chk({tag, "_hr"}, 32'(hr_out), hr);
      chk({tag, "_sps"}, 32'(steps_per_second), sps);
      chk({tag, "_stride"}, 32'(stride_length), stride);
      chk({tag, "_warm"}, 32'(warming_up), 0);
   endtask

   task automatic chk_quiet_window(input string tag);
      chk({tag, "_mid_valid"}, vhits, 0);
      chk({tag, "_valid"}, 32'(valid_out), 0);
      chk({tag, "_warm"}, 32'(warming_up), 1);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(valid_out), 0);
      chk("rst_hr", 32'(hr_out), 0);
      chk("rst_sps", 32'(steps_per_second), 0);
      chk("rst_stride", 32'(stride_length), 0);
      chk("rst_warm", 32'(warming_up), 0);

      // Scenario 1: four warm-up windows of 1 step / 2 beats -> hr 8*15=120
      rst = 1'b0;
      run = 1'b1;
      drive(1, 10'b0, 10'b0, -1, 8'd0);
      chk("s1_enter_warm", 32'(warming_up), 1);
      drive(10, 10'b1, 10'b101, -1, 8'd0); chk_quiet_window("s1_w1");
      drive(10, 10'b1, 10'b101, -1, 8'd0); chk_quiet_window("s1_w2");
      drive(10, 10'b1, 10'b101, -1, 8'd0); chk_quiet_window("s1_w3");
      drive(10, 10'b1, 10'b101, -1, 8'd0); chk_sample("s1_w4", 120, 1, 60);

      // Scenario 2: step saturation at 3, hr reaching and exceeding 255
      drive(10, 10'b0101010101, 10'b0101010101, -1, 8'd0); chk_sample("s2_w5", 165, 3, 60); // 5+2+2+2
      drive(10, 10'b0, 10'b0101010101, -1, 8'd0);          chk_sample("s2_w6", 210, 0, 60); // 5+5+2+2
      drive(10, 10'b0, 10'b0101010101, -1, 8'd0);          chk_sample("s2_w7", 255, 0, 60); // 17*15
      drive(10, 10'b0, 10'b0101010101, -1, 8'd0);          chk_sample("s2_w8", 255, 0, 60); // 300 clamped

      // Scenario 3: beat edge in the close cycle belongs to the closing window
      drive(10, 10'b0, 10'b1000000000, -1, 8'd0); chk_sample("s3_close_edge", 240, 0, 60); // 1+5+5+5
      drive(10, 10'b0, 10'b0, -1, 8'd0);          chk_sample("s3_next_zero", 165, 0, 60);  // 1+0+5+5

      // Stride change at counter 3 of a RUN window
      drive(10, 10'b101, 10'b0, 3, 8'd75); chk_sample("s6_stride", 90, 2, 75); // 1+0+0+5

      // Scenario 4: run dropped at counter 5, partial window discarded
      drive(5, 10'b10101, 10'b10101, -1, 8'd0);
      run = 1'b0;
      drive(3, 10'b0, 10'b0, -1, 8'd0);
      chk("s4_drop_mid_valid", vhits, 0);
      chk("s4_drop_valid", 32'(valid_out), 0);
      chk("s4_idle_warm", 32'(warming_up), 0);
      chk("s4_hold_hr", 32'(hr_out), 90);
      chk("s4_hold_sps", 32'(steps_per_second), 2);
      run = 1'b1;
      drive(1, 10'b0, 10'b0, -1, 8'd0);
      chk("s4_rewarm", 32'(warming_up), 1);
      drive(10, 10'b0, 10'b1, -1, 8'd0); chk_quiet_window("s4_w1");
      drive(10, 10'b0, 10'b1, -1, 8'd0); chk_quiet_window("s4_w2");
      drive(10, 10'b0, 10'b1, -1, 8'd0); chk_quiet_window("s4_w3");
      drive(10, 10'b1, 10'b1, -1, 8'd0); chk_sample("s4_w4", 60, 1, 75);

      // Scenario 5: reset in the close cycle of warm-up window 4
      run = 1'b0;
      drive(1, 10'b0, 10'b0, -1, 8'd0);
      run = 1'b1;
      drive(1, 10'b0, 10'b0, -1, 8'd0);
      drive(10, 10'b0, 10'b101, -1, 8'd0); chk_quiet_window("s5_w1");
      drive(10, 10'b0, 10'b101, -1, 8'd0); chk_quiet_window("s5_w2");
      drive(10, 10'b0, 10'b101, -1, 8'd0); chk_quiet_window("s5_w3");
      drive(9, 10'b0, 10'b101, -1, 8'd0);
      chk("s5_pre_mid_valid", vhits, 0);
      rst = 1'b1;
      drive(1, 10'b0, 10'b0, -1, 8'd0);
      chk("s5_valid", 32'(valid_out), 0);
      chk("s5_hr", 32'(hr_out), 0);
      chk("s5_sps", 32'(steps_per_second), 0);
      chk("s5_stride", 32'(stride_length), 0);
      chk("s5_warm", 32'(warming_up), 0);

      // Scenario 6: step level held high across reset release is not a step
      drive(2, 10'b11, 10'b0, -1, 8'd0);
      rst = 1'b0;
      drive(1, 10'b1, 10'b0, -1, 8'd0);
      chk("s6_warm", 32'(warming_up), 1);
      drive(10, 10'h3FF, 10'b1, -1, 8'd0); chk_quiet_window("s6_w1");
      drive(10, 10'h3FF, 10'b1, -1, 8'd0); chk_quiet_window("s6_w2");
      drive(10, 10'h3FF, 10'b1, -1, 8'd0); chk_quiet_window("s6_w3");
      drive(10, 10'h3FF, 10'b1, -1, 8'd0); chk_sample("s6_w4", 60, 0, 75);
      drive(1, 10'h3FF, 10'b0, -1, 8'd0);
      chk("s6_strobe_one_cycle", 32'(valid_out), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
